// File: rtl/switch_toggle_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : switch_toggle_multi_pkg
// Brief   : Shared edge-mode encodings and board debounce default for the
//           multi-channel switch toggle block.
// Revision: 1.0 - initial release
// ============================================================================
package switch_toggle_multi_pkg;

  // Raw EDGE_MODE parameter values
  localparam int EDGE_RELEASE = 0;
  localparam int EDGE_PRESS   = 1;
  localparam int EDGE_BOTH    = 2;

  // 10 ms at the 25 MHz board clock
  localparam int DEBOUNCE_LIMIT_25MHZ = 250000;

  typedef enum logic [1:0] {
    MODE_RELEASE = 2'd0,
    MODE_PRESS   = 2'd1,
    MODE_BOTH    = 2'd2
  } edge_mode_e;

  // Any unrecognised parameter value falls back to release-edge toggling.
  function automatic edge_mode_e decode_edge_mode(input int mode);
    case (mode)
      EDGE_PRESS: return MODE_PRESS;
      EDGE_BOTH:  return MODE_BOTH;
      default:    return MODE_RELEASE;
    endcase
  endfunction

endpackage : switch_toggle_multi_pkg
`default_nettype wire

// File: rtl/switch_toggle_multi_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module  : switch_debounce_ch
// Brief   : One channel: two-flop synchroniser, stability counter and the
//           debounced level register.
// Revision: 1.0 - initial release
// ============================================================================
module switch_debounce_ch
  import switch_toggle_multi_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_25MHZ
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Switch
);

  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_deb;
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_Switch;
      r_sync2 <= r_sync1;
      // Any cycle of agreement restarts the stability window.
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  assign o_Switch = r_deb;

endmodule : switch_debounce_ch
`default_nettype wire

// File: rtl/switch_toggle_multi.sv
`default_nettype none
// ============================================================================
// Module  : switch_toggle_multi
// Brief   : NUM_SW debounced switch channels, each toggling its LED and
//           pulsing an event on the selected edge of the debounced level.
// Revision: 1.0 - initial release
// ============================================================================
module switch_toggle_multi
  import switch_toggle_multi_pkg::*;
#(
  parameter int NUM_SW         = 4,
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_25MHZ,
  parameter int EDGE_MODE      = EDGE_RELEASE
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_SW-1:0] i_Switch,
  input  logic              i_Clear,
  output logic [NUM_SW-1:0] o_LED,
  output logic [NUM_SW-1:0] o_Sw_Debounced,
  output logic [NUM_SW-1:0] o_Event
);

  localparam edge_mode_e c_MODE = decode_edge_mode(EDGE_MODE);

  logic [NUM_SW-1:0] w_deb;
  logic [NUM_SW-1:0] w_rise;
  logic [NUM_SW-1:0] w_fall;
  logic [NUM_SW-1:0] w_qual;
  logic [NUM_SW-1:0] r_prev;
  logic [NUM_SW-1:0] r_led;
  logic [NUM_SW-1:0] r_event;

  generate
    for (genvar n = 0; n < NUM_SW; n++) begin : g_ch
      switch_debounce_ch #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
      ) u_debounce (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Switch(i_Switch[n]),
        .o_Switch(w_deb[n])
      );
    end
  endgenerate

  assign w_rise = w_deb & ~r_prev;
  assign w_fall = ~w_deb & r_prev;

  always_comb begin
    w_qual = w_fall;
    case (c_MODE)
      MODE_PRESS: w_qual = w_rise;
      MODE_BOTH:  w_qual = w_rise | w_fall;
      default:    w_qual = w_fall;
    endcase
  end

  // Clear overrides toggling, but the event pulse is still reported.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_prev  <= '0;
      r_event <= '0;
      r_led   <= '0;
    end else begin
      r_prev  <= w_deb;
      r_event <= w_qual;
      if (i_Clear) begin
        r_led <= '0;
      end else begin
        r_led <= r_led ^ w_qual;
      end
    end
  end

  assign o_LED          = r_led;
  assign o_Sw_Debounced = w_deb;
  assign o_Event        = r_event;

endmodule : switch_toggle_multi
`default_nettype wire

// File: tb/tb_switch_toggle_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_switch_toggle_multi
// Brief   : Directed bench; four instances share stimulus, one per EDGE_MODE
//           0..3 (3 must act as release mode), DEBOUNCE_LIMIT=4.
// Revision: 1.0 - initial release
// ============================================================================
module tb_switch_toggle_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [3:0] sw;

  logic [3:0] led[4];
  logic [3:0] deb[4];
  logic [3:0] ev[4];

  logic [3:0] ev_acc[4];
  int         ev_cnt[4][4];
  int         n_total = 0;
  int         n_bad   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar m = 0; m < 4; m++) begin : g_dut
      switch_toggle_multi #(
        .NUM_SW        (4),
        .DEBOUNCE_LIMIT(4),
        .EDGE_MODE     (m)
      ) u_dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Switch      (sw),
        .i_Clear       (clr),
        .o_LED         (led[m]),
        .o_Sw_Debounced(deb[m]),
        .o_Event       (ev[m])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_acc();
    for (int d = 0; d < 4; d++) begin
      ev_acc[d] = '0;
      for (int c = 0; c < 4; c++) ev_cnt[d][c] = 0;
    end
  endtask

  // Advance one clock and sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      ev_acc[d] = ev_acc[d] | ev[d];
      for (int c = 0; c < 4; c++) if (ev[d][c] === 1'b1) ev_cnt[d][c]++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    sw  = 4'b0000;
    clr_acc();
    ticks(3);
    rst = 1'b0;
    ticks(2);

    // 1: asynchronous reset mid-clock, then idle
    #3 rst = 1'b1;
    #1;
    chk("rst_led", {28'd0, led[0]}, 32'h0);
    chk("rst_deb", {28'd0, deb[0]}, 32'h0);
    chk("rst_ev",  {28'd0, ev[0]},  32'h0);
    tick();
    rst = 1'b0;
    clr_acc();
    ticks(20);
    chk("idle_ev", {16'd0, ev_acc[0], ev_acc[1], ev_acc[2], ev_acc[3]}, 32'h0);

    // 2: clean press/release on channel 0
    clr_acc();
    sw = 4'b0001;
    ticks(5);
    chk("t2_deb_pre",  {28'd0, deb[0]}, 32'h0);
    tick();
    chk("t2_deb_rise", {28'd0, deb[0]}, 32'h1);
    ticks(4);
    chk("t2_no_press_ev", {28'd0, ev_acc[0]}, 32'h0);
    sw = 4'b0000;
    clr_acc();
    ticks(5);
    chk("t2_deb_hold", {28'd0, deb[0]}, 32'h1);
    tick();
    chk("t2_deb_fall", {28'd0, deb[0]}, 32'h0);
    chk("t2_ev_early", {28'd0, ev_acc[0]}, 32'h0);
    tick();
    chk("t2_ev",  {28'd0, ev[0]},  32'h1);
    chk("t2_led", {28'd0, led[0]}, 32'h1);
    tick();
    chk("t2_ev_one",   {28'd0, ev[0]},  32'h0);
    chk("t2_led_m1",   {28'd0, led[1]}, 32'h1);
    chk("t2_led_m2",   {28'd0, led[2]}, 32'h0);
    chk("t2_led_m3",   {28'd0, led[3]}, 32'h1);

    // 3: bounce rejection on channel 1
    clr_acc();
    for (int r = 0; r < 2; r++) begin
      sw[1] = 1'b1;
      ticks(2);
      sw[1] = 1'b0;
      ticks(2);
    end
    sw[1] = 1'b1;
    ticks(5);
    chk("t3_deb_pre",  {28'd0, deb[1]}, 32'h0);
    chk("t3_ev_pre",   {28'd0, ev_acc[1]}, 32'h0);
    tick();
    chk("t3_deb_rise", {28'd0, deb[1]}, 32'h2);
    tick();
    chk("t3_ev_m1",  {28'd0, ev[1]},  32'h2);
    chk("t3_led_m1", {28'd0, led[1]}, 32'h3);
    sw[1] = 1'b0;
    ticks(10);
    chk("t3_cnt_m1",     ev_cnt[1][1], 32'd1);
    chk("t3_led_m1_end", {28'd0, led[1]}, 32'h3);
    chk("t3_cnt_m2",     ev_cnt[2][1], 32'd2);
    chk("t3_led_m2_end", {28'd0, led[2]}, 32'h0);
    chk("t3_led_m0_end", {28'd0, led[0]}, 32'h3);

    // 4: both-edge mode on channel 2
    clr_acc();
    sw[2] = 1'b1;
    ticks(7);
    chk("t4_led_m2_mid", {28'd0, led[2]}, 32'h4);
    ticks(3);
    sw[2] = 1'b0;
    ticks(10);
    chk("t4_cnt_m2",     ev_cnt[2][2], 32'd2);
    chk("t4_led_m2_end", {28'd0, led[2]}, 32'h0);
    chk("t4_led_m0",     {28'd0, led[0]}, 32'h7);
    chk("t4_led_m1",     {28'd0, led[1]}, 32'h7);
    chk("t4_led_m3",     {28'd0, led[3]}, 32'h7);

    // 5: simultaneous release on channels 0 and 3 with clear
    clr_acc();
    sw = 4'b1001;
    ticks(10);
    chk("t5_led_m1_press", {28'd0, led[1]}, 32'he);
    sw = 4'b0000;
    ticks(6);
    clr = 1'b1;
    tick();
    chk("t5_ev_m0",  {28'd0, ev[0]},  32'h9);
    chk("t5_ev_m2",  {28'd0, ev[2]},  32'h9);
    chk("t5_led_m0", {28'd0, led[0]}, 32'h0);
    chk("t5_led_m1", {28'd0, led[1]}, 32'h0);
    chk("t5_led_m2", {28'd0, led[2]}, 32'h0);
    clr = 1'b0;
    tick();
    chk("t5_ev_one", {28'd0, ev[0]},  32'h0);
    chk("t5_led_m0_after", {28'd0, led[0]}, 32'h0);

    // 6: reset while channel 0 counter is at 3 of 4
    sw = 4'b1000;
    ticks(10);
    chk("t6_led_m1_pre", {28'd0, led[1]}, 32'h8);
    sw = 4'b1001;
    ticks(5);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_led", {28'd0, led[1]}, 32'h0);
    chk("t6_rst_deb", {28'd0, deb[0]}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    clr_acc();
    ticks(5);
    chk("t6_deb_pre",  {28'd0, deb[0]}, 32'h0);
    tick();
    chk("t6_deb_rise", {28'd0, deb[0]}, 32'h9);
    tick();
    chk("t6_led_m0", {28'd0, led[0]}, 32'h0);
    chk("t6_led_m1", {28'd0, led[1]}, 32'h9);
    chk("t6_ev_m1",  {28'd0, ev[1]},  32'h9);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_switch_toggle_multi
`default_nettype wire

// File: doc/switch_toggle_multi.md
Name: switch_toggle_multi

Overview:
- Parametrised multi-channel switch-to-LED toggle block.
- Each of NUM_SW switch inputs is synchronised to i_Clk, debounced with a per-channel stability counter, and edge-detected in a selectable mode.
- Each qualifying edge toggles that channel's LED and emits a one-cycle event pulse.
- Sits between board pushbuttons and LED/user logic; replaces single-switch, undebounced toggle logic.

Parameters:
- NUM_SW, 4, number of independent switch/LED channels (>=1).
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles required before the debounced state changes (>=1; 10 ms at 25 MHz).
- EDGE_MODE, 0, edge that toggles: 0 = release (1->0), 1 = press (0->1), 2 = both.

Ports:
- i_Clk  input  1  system clock.
- i_Rst  input  1  reset; asynchronous, active-high.
- i_Switch  input  NUM_SW  raw, asynchronous switch levels; 1 = pressed.
- i_Clear  input  1  synchronous clear of all LED states.
- o_LED  output  NUM_SW  toggle state per channel.
- o_Sw_Debounced  output  NUM_SW  debounced switch level per channel.
- o_Event  output  NUM_SW  one-cycle pulse per qualifying edge.

Behaviour:
- Reset (i_Rst=1, asynchronous assert): all sync flops, counters, debounced state, o_LED, o_Sw_Debounced and o_Event go to 0 immediately and hold while asserted.
  - A bounce in progress when reset asserts is discarded.
  - After deassertion, a switch already held at 1 is treated as a fresh 0->1 change and must still pass the full debounce.
- Synchroniser: two flops per channel (sync1, sync2). sync2 is the debouncer input.
- Debounce, per channel:
  - If sync2 == debounced, the counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the counter == DEBOUNCE_LIMIT-1 and sync2 != debounced still holds, debounced <= sync2 and the counter clears.
  - Net effect: debounced changes after exactly DEBOUNCE_LIMIT consecutive mismatching cycles. Any single cycle of agreement restarts the count.
  - Counter width is $clog2(DEBOUNCE_LIMIT+1). The counter never wraps.
  - DEBOUNCE_LIMIT=1: debounced follows sync2 with one cycle of delay.
- o_Sw_Debounced is the debounced register itself, with no extra delay.
- Edge detect:
  - A previous-debounced register is updated every cycle.
  - rise = deb & ~prev; fall = ~deb & prev.
  - Qualify = fall (mode 0), rise (mode 1), or rise|fall (mode 2).
- o_Event[n]: registered; asserted for exactly one cycle, on the edge after the debounced change.
- LED:
  - On the same edge that asserts o_Event[n], o_LED[n] <= ~o_LED[n].
  - If i_Clear=1 on that edge, o_LED <= 0 for all channels. Clear wins over toggle.
  - o_Event still pulses when clear and toggle coincide.
- Latency from a clean input step to o_Event/LED change: 2 (sync) + DEBOUNCE_LIMIT + 1 cycles.
- Channels are fully independent. Simultaneous events on several channels each toggle their own LED in the same cycle.
- EDGE_MODE outside 0..2 behaves as mode 0.

Decomposition:
- Shared include/package holds:
  - EDGE_RELEASE=0, EDGE_PRESS=1, EDGE_BOTH=2.
  - The default DEBOUNCE_LIMIT for the 25 MHz board clock.
- Natural sub-module: switch_debounce_ch (synchroniser, counter, debounced register; parameter DEBOUNCE_LIMIT; ports i_Clk, i_Rst, i_Switch, o_Switch).
- The top instantiates it NUM_SW times via generate, plus per-channel edge/LED logic.

Test Plan:
1. Reset/idle: NUM_SW=4, DEBOUNCE_LIMIT=4, mode 0; pulse i_Rst mid-clock -> all outputs 0 immediately; no o_Event for 20 cycles with i_Switch=0.
2. Clean release: i_Switch[0] 0->1, held 10 cycles, then ->0 -> o_Sw_Debounced[0] rises 6 cycles after the press; o_Event[0] pulses one cycle exactly 7 cycles after the release; o_LED = 4'b0001; no event on the press.
3. Bounce rejection: i_Switch[1] toggles 1,0,1,0 every 2 cycles, then held 1 -> no debounced change until 4 consecutive stable cycles; exactly one debounced rise. Mode 1: o_LED[1] toggles once.
4. Mode 2: one press+release on channel 2 -> two o_Event[2] pulses; o_LED[2] ends at 0 after toggling 0->1->0.
5. Simultaneous/clear: channels 0 and 3 released in the same cycle with i_Clear=1 on the event cycle -> o_Event=4'b1001 for one cycle; o_LED=4'b0000 afterwards.
6. Reset mid-bounce: i_Rst asserted with channel 0 counter at 3 of 4, switch still held -> after deassert, debounced rises only after 2+4 further cycles; LED state is 0.
